// File: rtl/bcd_entry_controller.sv
// Signed 3-digit BCD entry controller: buttons edit a live buffer; a center press commits it. Latency: edits and commits visible 1 clk after the pulse.
// Backpressure: value_valid/value_out hold until value_ready; all buttons are ignored while busy.
module bcd_entry_controller #(
  parameter bit         CLEAR_ON_COMMIT = 1'b0,
  parameter logic [1:0] INIT_DIGIT      = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic        value_ready,
  output logic [12:0] display_input,
  output logic [1:0]  current_digit,
  output logic [12:0] value_out,
  output logic        value_valid,
  output logic        busy
);

  typedef enum logic {ST_EDIT, ST_WAIT_ACK} state_t;

  typedef struct packed {
    logic       sign;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_val_t;

  state_t     state_q, state_d;
  bcd_val_t   buf_q, buf_d;
  bcd_val_t   vout_q, vout_d;
  logic [1:0] cursor_q, cursor_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  // Treating anything >= 9 as the wrap point keeps nibbles inside 0..9.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    vout_d   = vout_q;
    cursor_d = cursor_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    case (state_q)
      ST_EDIT: begin
        if (btn_center) begin
          // A zero magnitude always commits as +000, whatever the sign bit says.
          if (buf_q.d2 == 4'd0 && buf_q.d1 == 4'd0 && buf_q.d0 == 4'd0) begin
            vout_d = '0;
          end else begin
            vout_d = buf_q;
          end
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_WAIT_ACK;
        end else if (btn_up || btn_down) begin
          case (cursor_q)
            2'd0:    buf_d.d0 = btn_up ? bcd_inc(buf_q.d0) : bcd_dec(buf_q.d0);
            2'd1:    buf_d.d1 = btn_up ? bcd_inc(buf_q.d1) : bcd_dec(buf_q.d1);
            2'd2:    buf_d.d2 = btn_up ? bcd_inc(buf_q.d2) : bcd_dec(buf_q.d2);
            default: buf_d.sign = ~buf_q.sign;
          endcase
        end else if (btn_left) begin
          cursor_d = cursor_q + 2'd1;
        end else if (btn_right) begin
          cursor_d = cursor_q - 2'd1;
        end
      end
      ST_WAIT_ACK: begin
        if (value_ready) begin
          valid_d  = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_EDIT;
          cursor_d = INIT_DIGIT;
          if (CLEAR_ON_COMMIT) begin
            buf_d = '0;
          end
        end
      end
      default: state_d = ST_EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EDIT;
      buf_q    <= '0;
      vout_q   <= '0;
      cursor_q <= INIT_DIGIT;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      vout_q   <= vout_d;
      cursor_q <= cursor_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign display_input = buf_q;
  assign current_digit = cursor_q;
  assign value_out     = vout_q;
  assign value_valid   = valid_q;
  assign busy          = busy_q;

endmodule

// File: doc/bcd_entry_controller.md
BCD_ENTRY_CONTROLLER -- requirements
Module: bcd_entry_controller

Interface
REQ-001 Parameter CLEAR_ON_COMMIT, default 0; when 1, edit buffer returns to +000 after each accepted commit.
REQ-002 Parameter INIT_DIGIT, default 2'd0; cursor position after reset and after each accepted commit.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 btn_up  input  1  one-cycle synchronous pulse: increment the digit under the cursor.
REQ-006 btn_down  input  1  one-cycle pulse: decrement the digit under the cursor.
REQ-007 btn_left  input  1  one-cycle pulse: move cursor one digit left (toward sign).
REQ-008 btn_right  input  1  one-cycle pulse: move cursor one digit right.
REQ-009 btn_center  input  1  one-cycle pulse: request commit of the edit buffer.
REQ-010 value_ready  input  1  downstream accepts value_out when high with value_valid.
REQ-011 display_input  output  13  {sign, d2, d1, d0}, sign = bit 12, d0 = bits 3:0; live edit buffer for the 7-seg driver.
REQ-012 current_digit  output  2  cursor: 0 = d0, 1 = d1, 2 = d2, 3 = sign position.
REQ-013 value_out  output  13  committed value, same packing as display_input.
REQ-014 value_valid  output  1  committed value pending.
REQ-015 busy  output  1  high in WAIT_ACK state.

Function
REQ-016 Two-state FSM: EDIT and WAIT_ACK; all outputs registered.
REQ-017 EDIT, btn_center -> latch buffer into value_out, set value_valid next cycle, go to WAIT_ACK.
REQ-018 Negative zero (sign=1, digits 000) is committed as +000; the edit buffer is left unchanged.
REQ-019 WAIT_ACK: value_valid and value_out held stable until the cycle value_ready=1; that edge clears value_valid, returns to EDIT, sets cursor to INIT_DIGIT, and applies CLEAR_ON_COMMIT.
REQ-020 value_ready high on the same cycle value_valid rises completes the handshake on that edge (minimum one cycle valid).
REQ-021 All buttons ignored in WAIT_ACK; busy=1 throughout WAIT_ACK.
REQ-022 Multiple buttons on one cycle: act only on the highest priority, center > up > down > left > right; others dropped.
REQ-023 btn_up on a digit: 0..8 -> +1, 9 -> 0, no carry into neighbour digits.
REQ-024 btn_down on a digit: 1..9 -> -1, 0 -> 9, no borrow.
REQ-025 btn_up or btn_down with the cursor at 3 toggles the sign.
REQ-026 btn_left: cursor +1 mod 4 (3 -> 0); btn_right: cursor -1 mod 4 (0 -> 3).
REQ-027 Digit nibbles never hold values above 9 (A-F) under any input sequence.
REQ-028 An edit takes effect on display_input / current_digit one clock after the pulse.

Reset
REQ-029 rst_n low, at any time including WAIT_ACK, asynchronously forces: state=EDIT, display_input=13'h0000, value_out=13'h0000, value_valid=0, busy=0, current_digit=INIT_DIGIT.
REQ-030 First button acted on is the one on the first rising edge with rst_n high.

Verification
REQ-031 Reset, then btn_up x3 at cursor 0 -> display_input=13'h0003, current_digit=0.
REQ-032 btn_down at d0=0 -> d0=9; btn_right at cursor 0 -> cursor 3; btn_up -> display_input=13'h1009.
REQ-033 Buffer -000, btn_center, value_ready=0 for 5 cycles then 1 -> value_out=13'h0000, value_valid high 6 cycles, then low; busy tracks value_valid.
REQ-034 In WAIT_ACK, pulse every button -> display_input and current_digit unchanged; value_out stable.
REQ-035 btn_up+btn_left same cycle -> digit incremented, cursor unchanged; btn_center+btn_up -> commit only.
REQ-036 rst_n low mid-WAIT_ACK with CLEAR_ON_COMMIT=0 -> value_valid=0 and buffer=13'h0000 immediately, before the next clk edge.
